rice_core_csr_access: RTL

- Execute-side CSR instruction unit. Sits directly upstream of the core environment block and drives the 12-bit CSR bus that block serves as slave.
- Sequences CSRRW/CSRRS/CSRRC and their immediate forms (CSRRWI/CSRRSI/CSRRCI) as a read request followed by a non-posted write request.
- Returns the old CSR value for rd.
- Flags an illegal-instruction exception on a privilege violation, a write to a read-only CSR, or a bus error response.

---
 rtl/rice_core_csr_access_pkg.sv | 48 ++++
 rtl/rice_core_csr_alu.sv | 26 ++
 rtl/rice_core_csr_access.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/rice_core_csr_access_pkg.sv
// Shared definitions for the CSR access unit.
//   - priv_lvl_e  : privilege levels, encoded as in CSR address bits [9:8]
//   - csr_op_e    : funct3 encodings of the six CSR instructions
//   - csr_state_e : sequencing FSM states
//   - CSR address field positions and the read-only field value
package rice_core_csr_access_pkg;

  typedef enum logic [1:0] {
    PRIV_U    = 2'b00,
    PRIV_S    = 2'b01,
    PRIV_RSVD = 2'b10,
    PRIV_M    = 2'b11
  } priv_lvl_e;

  typedef enum logic [2:0] {
    CSR_OP_RW  = 3'b001,
    CSR_OP_RS  = 3'b010,
    CSR_OP_RC  = 3'b011,
    CSR_OP_RWI = 3'b101,
    CSR_OP_RSI = 3'b110,
    CSR_OP_RCI = 3'b111
  } csr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_REQ = 3'd1,
    ST_RD_RSP = 3'd2,
    ST_WR_REQ = 3'd3,
    ST_WR_RSP = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_DONE   = 3'd6
  } csr_state_e;

  // Address bits [11:10] == 2'b11 mark a read-only CSR.
  localparam logic [1:0] CSR_READ_ONLY_FIELD = 2'b11;
  localparam int unsigned CSR_RO_HI   = 11;
  localparam int unsigned CSR_RO_LO   = 10;
  // Address bits [9:8] hold the lowest privilege allowed to access the CSR.
  localparam int unsigned CSR_PRIV_HI = 9;
  localparam int unsigned CSR_PRIV_LO = 8;

  // RW and RWI share funct3[1:0] == 2'b01; these always write, and only
  // skip the read when rd is x0.
  function automatic logic csr_op_is_swap(input logic [2:0] funct3);
    return funct3[1:0] == 2'b01;
  endfunction

endpackage

// File: rtl/rice_core_csr_alu.sv
// New CSR value computation for the CSR access unit (combinational).
//   op_i      : funct3 of the instruction
//   old_i     : CSR value read from the bus (zero when no read was done)
//   operand_i : rs1 value or zero-extended uimm
//   new_o     : value to write back
module rice_core_csr_alu
  import rice_core_csr_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] old_i,
  input  logic [XLEN-1:0] operand_i,
  output logic [XLEN-1:0] new_o
);

  always_comb begin
    new_o = operand_i;
    case (csr_op_e'(op_i))
      CSR_OP_RS, CSR_OP_RSI: new_o = old_i | operand_i;
      CSR_OP_RC, CSR_OP_RCI: new_o = old_i & ~operand_i;
      default:               new_o = operand_i;
    endcase
  end

endmodule

// File: rtl/rice_core_csr_access.sv
// Execute-side CSR instruction unit. Each accepted instruction becomes an
// optional read request followed by an optional non-posted write request on
// the 12-bit CSR bus; the old CSR value is returned for rd.
//   i_valid/o_ready          : instruction handshake (ready only in IDLE)
//   i_funct3..i_privilege_level : instruction fields, sampled at accept
//   i_flush                  : abort the instruction in flight
//   o_csr_request_* / i_csr_request_ready : bus request channel
//   i_csr_response_*         : bus response channel (always accepted)
//   o_done + o_illegal_instruction/o_rd_write/o_rd_value : completion
module rice_core_csr_access
  import rice_core_csr_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_funct3,
  input  logic [11:0]     i_address,
  input  logic [XLEN-1:0] i_operand,
  input  logic            i_rs1_zero,
  input  logic            i_rd_zero,
  input  logic [1:0]      i_privilege_level,
  input  logic            i_flush,
  output logic            o_csr_request_valid,
  input  logic            i_csr_request_ready,
  output logic            o_csr_write,
  output logic [11:0]     o_csr_address,
  output logic [XLEN-1:0] o_csr_write_data,
  input  logic            i_csr_response_valid,
  input  logic            i_csr_response_error,
  input  logic [XLEN-1:0] i_csr_read_data,
  output logic            o_done,
  output logic            o_illegal_instruction,
  output logic            o_rd_write,
  output logic [XLEN-1:0] o_rd_value
);

  csr_state_e      state_q, state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [11:0]     addr_q, addr_d;
  logic [XLEN-1:0] operand_q, operand_d;
  logic            rd_zero_q, rd_zero_d;
  logic            do_read_q, do_read_d;
  logic            do_write_q, do_write_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] old_q, old_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  logic            acc_do_read, acc_do_write;
  logic            priv_violation, ro_violation;
  logic [2:0]      alu_op;
  logic [XLEN-1:0] alu_old, alu_operand, alu_new;
  logic            done_visible;

  assign acc_do_read  = !(csr_op_is_swap(i_funct3) && i_rd_zero);
  assign acc_do_write = !(!csr_op_is_swap(i_funct3) && i_rs1_zero);

  assign priv_violation = priv_lvl_e'(i_address[CSR_PRIV_HI:CSR_PRIV_LO])
                          > priv_lvl_e'(i_privilege_level);
  assign ro_violation   = acc_do_write
                          && (i_address[CSR_RO_HI:CSR_RO_LO] == CSR_READ_ONLY_FIELD);

  // The ALU result is only consumed on the way into WR_REQ: from IDLE
  // (write-only, old value is zero) or from RD_RSP (old value is on the bus).
  assign alu_op      = (state_q == ST_IDLE) ? i_funct3  : funct3_q;
  assign alu_operand = (state_q == ST_IDLE) ? i_operand : operand_q;
  assign alu_old     = (state_q == ST_RD_RSP) ? i_csr_read_data : '0;

  rice_core_csr_alu #(.XLEN(XLEN)) u_alu (
    .op_i      (alu_op),
    .old_i     (alu_old),
    .operand_i (alu_operand),
    .new_o     (alu_new)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      funct3_q   <= '0;
      addr_q     <= '0;
      operand_q  <= '0;
      rd_zero_q  <= 1'b0;
      do_read_q  <= 1'b0;
      do_write_q <= 1'b0;
      illegal_q  <= 1'b0;
      old_q      <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      operand_q  <= operand_d;
      rd_zero_q  <= rd_zero_d;
      do_read_q  <= do_read_d;
      do_write_q <= do_write_d;
      illegal_q  <= illegal_d;
      old_q      <= old_d;
      wdata_q    <= wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    operand_d  = operand_q;
    rd_zero_d  = rd_zero_q;
    do_read_d  = do_read_q;
    do_write_d = do_write_q;
    illegal_d  = illegal_q;
    old_d      = old_q;
    wdata_d    = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          funct3_d   = i_funct3;
          addr_d     = i_address;
          operand_d  = i_operand;
          rd_zero_d  = i_rd_zero;
          do_read_d  = acc_do_read;
          do_write_d = acc_do_write;
          illegal_d  = 1'b0;
          old_d      = '0;
          if (priv_violation || ro_violation) begin
            illegal_d = 1'b1;
            state_d   = ST_DONE;
          end else if (acc_do_read) begin
            state_d = ST_RD_REQ;
          end else begin
            wdata_d = alu_new;
            state_d = ST_WR_REQ;
          end
        end
      end
      ST_RD_REQ: begin
        // A flush on the handshake cycle still leaves a response to absorb.
        if (i_csr_request_ready) state_d = i_flush ? ST_DRAIN : ST_RD_RSP;
        else if (i_flush)        state_d = ST_IDLE;
      end
      ST_RD_RSP: begin
        if (i_csr_response_valid) begin
          if (i_flush) begin
            state_d = ST_IDLE;
          end else begin
            old_d = i_csr_read_data;
            if (i_csr_response_error) begin
              illegal_d = 1'b1;
              state_d   = ST_DONE;
            end else if (do_write_q) begin
              wdata_d = alu_new;
              state_d = ST_WR_REQ;
            end else begin
              state_d = ST_DONE;
            end
          end
        end else if (i_flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_WR_REQ: begin
        if (i_csr_request_ready) state_d = i_flush ? ST_DRAIN : ST_WR_RSP;
        else if (i_flush)        state_d = ST_IDLE;
      end
      ST_WR_RSP: begin
        if (i_csr_response_valid) begin
          if (i_flush) begin
            state_d = ST_IDLE;
          end else begin
            illegal_d = i_csr_response_error;
            state_d   = ST_DONE;
          end
        end else if (i_flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (i_csr_response_valid) state_d = ST_IDLE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_ready             = (state_q == ST_IDLE);
  assign o_csr_request_valid = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
  assign o_csr_write         = (state_q == ST_WR_REQ);
  assign o_csr_address       = addr_q;
  assign o_csr_write_data    = wdata_q;

  // A flush landing on the DONE cycle cancels the completion.
  assign done_visible          = (state_q == ST_DONE) && !i_flush;
  assign o_done                = done_visible;
  assign o_illegal_instruction = done_visible && illegal_q;
  assign o_rd_write            = done_visible && !illegal_q && do_read_q && !rd_zero_q;
  assign o_rd_value            = old_q;

endmodule
